fft_result_streamer: RTL and testbench

// - Drains finished FFT bins out of the result SRAM through mem_interface_sram port 1 (read side).
// - Presents them as a valid/ready stream with a last flag, for an off-core consumer.
// - Runs after fft_done; yields to scan-chain SRAM accesses.
// - Credit-based output FIFO: read data is never dropped under backpressure.

---
 rtl/fft_result_streamer.sv | 175 +++++++++++++++++
 tb/tb_fft_result_streamer.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fft_result_streamer.sv
// Drains N FFT result words from SRAM read port 1 into a valid/ready stream through a credit-checked FIFO.
// Optional macro FFT_STREAM_PARITY_EN adds o_tpar (per-32-bit-lane XOR parity, stored with each entry).
module fft_result_streamer #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 128,
    parameter int RD_LAT = 1,
    parameter int FIFO_D = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_start,
    input  logic              i_fft_done,
    input  logic [2:0]        i_point_cfg,
    input  logic [ADDR_W-1:0] i_base_addr,
    input  logic              i_hold,
    output logic              o_ren,
    output logic [ADDR_W-1:0] o_raddr,
    input  logic [DATA_W-1:0] i_rdata,
    output logic              o_tvalid,
    input  logic              i_tready,
    output logic [DATA_W-1:0] o_tdata,
    output logic              o_tlast,
    output logic              o_busy,
    output logic              o_done
`ifdef FFT_STREAM_PARITY_EN
    ,
    output logic [3:0]        o_tpar
`endif
);

    localparam int PTR_W = $clog2(FIFO_D);
    localparam int CNT_W = $clog2(FIFO_D + 1);
`ifdef FFT_STREAM_PARITY_EN
    localparam int ENT_W = DATA_W + 1 + 4;
`else
    localparam int ENT_W = DATA_W + 1;
`endif

    typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;

    state_t              state_q, state_d;
    logic [8:0]          n_q, n_d;
    logic [8:0]          issue_q, issue_d;
    logic [ADDR_W-1:0]   base_q, base_d;
    logic [RD_LAT-1:0]   vld_sr_q, vld_sr_d;
    logic [RD_LAT-1:0]   last_sr_q, last_sr_d;
    logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                done_q, done_d;
    logic [ENT_W-1:0]    mem_q [FIFO_D];
    logic [ENT_W-1:0]    entry_in, head;
    logic [CNT_W-1:0]    inflight;
    logic [CNT_W:0]      credit_sum;
    logic                credit_ok, ren, push, pop, is_last_issue;

    function automatic logic [3:0] lane_parity(input logic [DATA_W-1:0] d);
        logic [3:0] p;
        for (int k = 0; k < 4; k++) p[k] = ^d[32*k +: 32];
        return p;
    endfunction

    always_comb begin
        inflight = '0;
        for (int i = 0; i < RD_LAT; i++) inflight = inflight + CNT_W'(vld_sr_q[i]);
    end

    // Reads already in flight hold a FIFO slot, so a full pipeline can never overflow it.
    assign credit_sum    = {1'b0, cnt_q} + {1'b0, inflight};
    assign credit_ok     = credit_sum < (CNT_W+1)'(FIFO_D);
    assign is_last_issue = (issue_q == n_q - 9'd1);

    always_comb begin
        state_d = state_q;
        n_d     = n_q;
        base_d  = base_q;
        issue_d = issue_q;
        ren     = 1'b0;
        case (state_q)
            IDLE: begin
                if (i_start && i_fft_done) begin
                    state_d = READ;
                    n_d     = (i_point_cfg >= 3'd6) ? 9'd256 : (9'd4 << i_point_cfg);
                    base_d  = i_base_addr;
                    issue_d = '0;
                end
            end
            READ: begin
                ren = !i_hold && credit_ok;
                if (ren) begin
                    issue_d = issue_q + 9'd1;
                    if (is_last_issue) state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (inflight == '0 && cnt_q == '0) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        vld_sr_d     = vld_sr_q;
        last_sr_d    = last_sr_q;
        vld_sr_d[0]  = ren;
        last_sr_d[0] = is_last_issue;
        for (int i = 1; i < RD_LAT; i++) begin
            vld_sr_d[i]  = vld_sr_q[i-1];
            last_sr_d[i] = last_sr_q[i-1];
        end
    end

    assign push = vld_sr_q[RD_LAT-1];
    assign head = mem_q[rd_ptr_q];
    assign pop  = o_tvalid && i_tready;

`ifdef FFT_STREAM_PARITY_EN
    assign entry_in = {lane_parity(i_rdata), last_sr_q[RD_LAT-1], i_rdata};
    assign o_tpar   = o_tvalid ? head[DATA_W+4:DATA_W+1] : 4'h0;
`else
    assign entry_in = {last_sr_q[RD_LAT-1], i_rdata};
`endif

    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        cnt_d    = cnt_q;
        if (push && !pop)      cnt_d = cnt_q + CNT_W'(1);
        else if (pop && !push) cnt_d = cnt_q - CNT_W'(1);
        done_d   = pop && head[DATA_W];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            n_q      <= '0;
            issue_q  <= '0;
            base_q   <= '0;
            vld_sr_q <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            n_q      <= n_d;
            issue_q  <= issue_d;
            base_q   <= base_d;
            vld_sr_q <= vld_sr_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            done_q   <= done_d;
        end
    end

    // Payload storage is qualified by the valid shift register and FIFO count, so it needs no reset.
    always_ff @(posedge clk) begin
        last_sr_q <= last_sr_d;
        if (push) mem_q[wr_ptr_q] <= entry_in;
    end

    assign o_ren    = ren;
    assign o_raddr  = base_q + ADDR_W'(issue_q);
    assign o_tvalid = (cnt_q != '0);
    assign o_tdata  = o_tvalid ? head[DATA_W-1:0] : '0;
    assign o_tlast  = o_tvalid && head[DATA_W];
    assign o_busy   = (state_q != IDLE);
    assign o_done   = done_q;

`ifndef SYNTHESIS
    a_no_overflow: assert property (@(posedge clk) disable iff (rst)
        !(push && !pop && cnt_q == CNT_W'(FIFO_D)));
`endif

endmodule

// File: tb/tb_fft_result_streamer.sv
// Randomized self-checking bench for fft_result_streamer against an SRAM model and an address/beat reference.
module tb_fft_result_streamer;
    localparam int ADDR_W = 8;
    localparam int DATA_W = 128;
    localparam int RD_LAT = 1;
    localparam int FIFO_D = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              i_start, i_fft_done, i_hold, i_tready;
    logic [2:0]        i_point_cfg;
    logic [ADDR_W-1:0] i_base_addr;
    logic              o_ren, o_tvalid, o_tlast, o_busy, o_done;
    logic [ADDR_W-1:0] o_raddr;
    logic [DATA_W-1:0] i_rdata, o_tdata;
`ifdef FFT_STREAM_PARITY_EN
    logic [3:0]        o_tpar;
`endif

    int total = 0;
    int passed = 0;

    always #5 clk = ~clk;

    fft_result_streamer #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(RD_LAT), .FIFO_D(FIFO_D)) dut (
        .clk(clk), .rst(rst), .i_start(i_start), .i_fft_done(i_fft_done),
        .i_point_cfg(i_point_cfg), .i_base_addr(i_base_addr), .i_hold(i_hold),
        .o_ren(o_ren), .o_raddr(o_raddr), .i_rdata(i_rdata), .o_tvalid(o_tvalid),
        .i_tready(i_tready), .o_tdata(o_tdata), .o_tlast(o_tlast), .o_busy(o_busy),
        .o_done(o_done)
`ifdef FFT_STREAM_PARITY_EN
        , .o_tpar(o_tpar)
`endif
    );

    // SRAM model with RD_LAT-cycle read latency
    logic [DATA_W-1:0] sram [256];
    logic [DATA_W-1:0] rd_pipe [RD_LAT];
    always @(posedge clk) begin
        if (o_ren) rd_pipe[0] <= sram[o_raddr];
        for (int i = 1; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
    end
    assign i_rdata = rd_pipe[RD_LAT-1];

    // Monitor: records issued addresses and accepted beats, away from the active edge
    logic [7:0]        q_addr [$];
    logic [DATA_W-1:0] q_data [$];
    logic              q_last [$];
    logic [3:0]        q_par  [$];
    int cyc = 0, done_cnt = 0, done_cyc = -1, last_hs_cyc = -100, ren_hold_cnt = 0, stab_err = 0;
    logic prev_stall = 1'b0;
    logic [DATA_W-1:0] prev_data;
    always @(negedge clk) begin
        cyc++;
        if (o_ren) begin
            q_addr.push_back(o_raddr);
            if (i_hold) ren_hold_cnt++;
        end
        if (prev_stall && !rst && !(o_tvalid && o_tdata == prev_data)) stab_err++;
        prev_stall = o_tvalid && !i_tready && !rst;
        prev_data  = o_tdata;
        if (o_tvalid && i_tready) begin
            q_data.push_back(o_tdata);
            q_last.push_back(o_tlast);
`ifdef FFT_STREAM_PARITY_EN
            q_par.push_back(o_tpar);
`else
            q_par.push_back(4'h0);
`endif
            if (o_tlast) last_hs_cyc = cyc;
        end
        if (o_done) begin
            done_cnt++;
            done_cyc = cyc;
        end
    end

    function automatic logic [3:0] ref_par(input logic [DATA_W-1:0] w);
        logic [3:0] p;
        for (int k = 0; k < 4; k++) p[k] = ($countones(w[32*k +: 32]) % 2) == 1;
        return p;
    endfunction

    // Reference: drain k reads word (base+k) mod 256, last flag only on k = N-1
    task automatic score(input int cfg, input logic [7:0] base, input int a0, input int b0,
                         output int n_exp, output int n_addr, output int n_beat, output int errs);
        logic [7:0] ea;
        n_exp  = (cfg >= 6) ? 256 : (4 << cfg);
        n_addr = q_addr.size() - a0;
        n_beat = q_data.size() - b0;
        errs   = 0;
        for (int i = 0; i < n_exp; i++) begin
            ea = base + 8'(i);
            if (i < n_addr && q_addr[a0+i] !== ea) errs++;
            if (i < n_beat) begin
                if (q_data[b0+i] !== sram[ea]) errs++;
                if (q_last[b0+i] !== (i == n_exp - 1)) errs++;
`ifdef FFT_STREAM_PARITY_EN
                if (q_par[b0+i] !== ref_par(sram[ea])) errs++;
`endif
            end
        end
    endtask

    task automatic start_drain(input logic [2:0] cfg, input logic [7:0] base);
        @(posedge clk); #1;
        i_point_cfg = cfg;
        i_base_addr = base;
        i_start = 1'b1;
        @(posedge clk); #1;
        i_start = 1'b0;
    endtask

    // mode 0: ready/no hold, 1: hold toggles every cycle, 2: random ready and hold
    task automatic wait_done(input int mode, input int d0, output logic timed_out);
        int c = 0;
        while (done_cnt == d0 && c < 3000) begin
            @(posedge clk); #1;
            if (mode == 1) i_hold = ~i_hold;
            if (mode == 2) begin
                i_tready = ($urandom_range(0, 3) != 0);
                i_hold   = ($urandom_range(0, 3) == 0);
            end
            c++;
        end
        timed_out = (done_cnt == d0);
        i_hold   = 1'b0;
        i_tready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #1;
        total++; if (o_ren !== 1'b0)    $display("FAIL reset_ren: got %b want 0", o_ren);       else passed++;
        total++; if (o_raddr !== 8'h00) $display("FAIL reset_raddr: got %h want 00", o_raddr);  else passed++;
        total++; if (o_tvalid !== 1'b0) $display("FAIL reset_tvalid: got %b want 0", o_tvalid); else passed++;
        total++; if (o_tdata !== '0)    $display("FAIL reset_tdata: got %h want 0", o_tdata);   else passed++;
        total++; if (o_tlast !== 1'b0)  $display("FAIL reset_tlast: got %b want 0", o_tlast);  else passed++;
        total++; if (o_busy !== 1'b0)   $display("FAIL reset_busy: got %b want 0", o_busy);     else passed++;
        total++; if (o_done !== 1'b0)   $display("FAIL reset_done: got %b want 0", o_done);     else passed++;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_drain(input string name, input logic [2:0] cfg, input logic [7:0] base, input int mode);
        int a0, b0, d0, h0, n_exp, n_addr, n_beat, errs;
        logic to;
        a0 = q_addr.size(); b0 = q_data.size(); d0 = done_cnt; h0 = ren_hold_cnt;
        start_drain(cfg, base);
        wait_done(mode, d0, to);
        score(cfg, base, a0, b0, n_exp, n_addr, n_beat, errs);
        total++; if (to)               $display("FAIL %s_timeout: done never seen", name);            else passed++;
        total++; if (n_addr !== n_exp) $display("FAIL %s_reads: got %0d want %0d", name, n_addr, n_exp); else passed++;
        total++; if (n_beat !== n_exp) $display("FAIL %s_beats: got %0d want %0d", name, n_beat, n_exp); else passed++;
        total++; if (errs !== 0)       $display("FAIL %s_content: got %0d errors want 0", name, errs);  else passed++;
        total++; if (done_cnt - d0 !== 1) $display("FAIL %s_done_count: got %0d want 1", name, done_cnt - d0); else passed++;
        total++; if (done_cyc !== last_hs_cyc + 1)
            $display("FAIL %s_done_timing: got cycle %0d want %0d", name, done_cyc, last_hs_cyc + 1); else passed++;
        total++; if (ren_hold_cnt - h0 !== 0)
            $display("FAIL %s_ren_in_hold: got %0d want 0", name, ren_hold_cnt - h0); else passed++;
    endtask

    task automatic test_backpressure();
        int a0, b0, d0, s0, n_exp, n_addr, n_beat, errs;
        logic to;
        a0 = q_addr.size(); b0 = q_data.size(); d0 = done_cnt; s0 = stab_err;
        i_tready = 1'b0;
        start_drain(3'd1, 8'h20);
        repeat (20) @(posedge clk);
        #1;
        total++; if (q_addr.size() - a0 !== FIFO_D)
            $display("FAIL bp_reads_stalled: got %0d want %0d", q_addr.size() - a0, FIFO_D); else passed++;
        total++; if (o_ren !== 1'b0) $display("FAIL bp_ren_low: got %b want 0", o_ren); else passed++;
        total++; if (stab_err - s0 !== 0) $display("FAIL bp_stable: got %0d changes want 0", stab_err - s0); else passed++;
        i_tready = 1'b1;
        wait_done(0, d0, to);
        score(1, 8'h20, a0, b0, n_exp, n_addr, n_beat, errs);
        total++; if (to) $display("FAIL bp_timeout: done never seen"); else passed++;
        total++; if (n_beat !== n_exp) $display("FAIL bp_beats: got %0d want %0d", n_beat, n_exp); else passed++;
        total++; if (errs !== 0) $display("FAIL bp_content: got %0d errors want 0", errs); else passed++;
    endtask

    task automatic test_reset_mid();
        int b0, c;
        b0 = q_data.size();
        c = 0;
        start_drain(3'd2, 8'h40);
        while (q_data.size() - b0 < 3 && c < 200) begin
            @(negedge clk);
            c++;
        end
        total++; if (q_data.size() - b0 < 3) $display("FAIL rstmid_three_beats: got %0d want 3", q_data.size() - b0); else passed++;
        @(posedge clk); #2;
        rst = 1'b1;
        #1;
        total++; if (o_busy !== 1'b0) $display("FAIL rstmid_busy: got %b want 0", o_busy); else passed++;
        total++; if ({o_ren, o_tvalid, o_tlast, o_done} !== 4'b0)
            $display("FAIL rstmid_ctrl: got %b want 0000", {o_ren, o_tvalid, o_tlast, o_done}); else passed++;
        total++; if (o_tdata !== '0 || o_raddr !== 8'h00)
            $display("FAIL rstmid_data: got %h/%h want 0/00", o_tdata, o_raddr); else passed++;
        @(posedge clk); #1;
        rst = 1'b0;
        test_drain("replay", 3'd2, 8'h40, 0);
    endtask

    task automatic test_no_done();
        int a0;
        a0 = q_addr.size();
        i_fft_done = 1'b0;
        start_drain(3'd0, 8'h00);
        repeat (10) @(posedge clk);
        #1;
        total++; if (q_addr.size() - a0 !== 0) $display("FAIL nodone_reads: got %0d want 0", q_addr.size() - a0); else passed++;
        total++; if (o_busy !== 1'b0) $display("FAIL nodone_busy: got %b want 0", o_busy); else passed++;
        i_fft_done = 1'b1;
    endtask

    task automatic test_random();
        for (int it = 0; it < 4; it++)
            test_drain("rand", 3'($urandom_range(0, 4)), 8'($urandom), 2);
        total++; if (stab_err !== 0) $display("FAIL stream_stability: got %0d changes want 0", stab_err); else passed++;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) sram[i] = {$urandom, $urandom, $urandom, $urandom};
        rst = 1'b1;
        i_start = 1'b0; i_fft_done = 1'b1; i_hold = 1'b0; i_tready = 1'b1;
        i_point_cfg = 3'd0; i_base_addr = 8'h00;
        test_reset();
        test_drain("basic", 3'd0, 8'h10, 0);
        test_drain("wrap", 3'd7, 8'h80, 0);
        test_backpressure();
        test_drain("hold", 3'd2, 8'hF8, 1);
        test_reset_mid();
        test_no_done();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
